// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external async 16-bit SRAM between two requesters.
// Round-robin arbitration, one access in flight, and fixed SETUP/ACCESS/HOLD
// sequencing of CS/OE/WE. Every SRAM-facing output and both done pulses come
// straight from flops so the strobes cannot glitch.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2  // OE/WE low width in cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  // Port 0
  input  logic        req0,
  input  logic        we0,
  input  logic [18:0] adr0,
  input  logic [15:0] wdat0,
  output logic        gnt0,
  output logic        done0,
  // Port 1
  input  logic        req1,
  input  logic        we1,
  input  logic [18:0] adr1,
  input  logic [15:0] wdat1,
  output logic        gnt1,
  output logic        done1,
  // Shared read data, held until the next read completes
  output logic [15:0] rdata,
  // SRAM pins
  output logic [18:0] sram_adr,
  output logic [15:0] sram_dat_o,
  output logic        sram_dat_oe,
  input  logic [15:0] sram_dat_i,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_cs_n
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_owner_q, last_owner_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        cs_n_q, cs_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        dat_oe_q, dat_oe_d;
  logic [18:0] adr_q, adr_d;
  logic [15:0] dat_o_q, dat_o_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;

  // Grant selection: only in IDLE; on contention the port that did not go last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0 && req1) begin
        gnt0 = last_owner_q;
        gnt1 = ~last_owner_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so they
  // can be registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    cs_n_d       = cs_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    dat_oe_d     = dat_oe_q;
    adr_d        = adr_q;
    dat_o_d      = dat_o_q;
    rdata_d      = rdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cs_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        dat_oe_d = 1'b0;
        if (gnt0 || gnt1) begin
          state_d      = StSetup;
          owner_d      = gnt1;
          last_owner_d = gnt1;
          we_d         = gnt1 ? we1 : we0;
          adr_d        = gnt1 ? adr1 : adr0;
          // The bus is driven from SETUP onwards for writes only.
          cs_n_d       = 1'b0;
          dat_oe_d     = gnt1 ? we1 : we0;
          if (gnt1 ? we1 : we0) begin
            dat_o_d = gnt1 ? wdat1 : wdat0;
          end
        end
      end

      StSetup: begin
        state_d = StAccess;
        cnt_d   = WaitInit;
        oe_n_d  = we_q;
        we_n_d  = ~we_q;
      end

      StAccess: begin
        if (cnt_q <= 4'd1) begin
          state_d = StHold;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (!we_q) begin
            rdata_d = sram_dat_i;
          end
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StHold: begin
        state_d  = StIdle;
        cs_n_d   = 1'b1;
        dat_oe_d = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset returns the pins to the idle level at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      cs_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      dat_oe_q     <= 1'b0;
      adr_q        <= 19'd0;
      dat_o_q      <= 16'd0;
      rdata_q      <= 16'd0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      cs_n_q       <= cs_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      dat_oe_q     <= dat_oe_d;
      adr_q        <= adr_d;
      dat_o_q      <= dat_o_d;
      rdata_q      <= rdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

  assign sram_cs_n   = cs_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_dat_oe = dat_oe_q;
  assign sram_adr    = adr_q;
  assign sram_dat_o  = dat_o_q;
  assign rdata       = rdata_q;
  assign done0       = done0_q;
  assign done1       = done1_q;

  // Bus-safety invariants.
  a_one_gnt: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  a_no_oe_we: assert property (@(posedge clk) disable iff (rst) !(!sram_oe_n && !sram_we_n));
  a_no_oe_drive: assert property (@(posedge clk) disable iff (rst) !(!sram_oe_n && sram_dat_oe));

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed stimulus against a timestamp-based
// reference model of the arbiter, plus latency/width checks on WAIT_CYCLES 1 and 15.
module tb_sram_arbiter;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [18:0] adr0, adr1;
  logic [15:0] wdat0, wdat1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rdata;
  logic [18:0] sram_adr;
  logic [15:0] sram_dat_o, sram_dat_i;
  logic        sram_dat_oe, sram_oe_n, sram_we_n, sram_cs_n;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .adr0(adr0), .wdat0(wdat0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .adr1(adr1), .wdat1(wdat1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .sram_adr(sram_adr), .sram_dat_o(sram_dat_o),
    .sram_dat_oe(sram_dat_oe), .sram_dat_i(sram_dat_i), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_cs_n(sram_cs_n)
  );

  // Extra builds for the WAIT_CYCLES extremes: index 0 -> 1, index 1 -> 15.
  logic        a_req0 [2];
  logic        a_we0  [2];
  logic [18:0] a_adr0 [2];
  logic [15:0] a_wdat0[2];
  logic        a_gnt0 [2];
  logic        a_done0[2];
  logic        a_gnt1 [2];
  logic        a_done1[2];
  logic [15:0] a_rdata[2];
  logic [18:0] a_sadr [2];
  logic [15:0] a_sdo  [2];
  logic        a_sdoe [2];
  logic        a_oe_n [2];
  logic        a_we_n [2];
  logic        a_cs_n [2];
  logic [15:0] a_sdi;

  for (genvar gi = 0; gi < 2; gi++) begin : g_alt
    sram_arbiter #(.WAIT_CYCLES(gi == 0 ? 1 : 15)) u_alt (
      .clk(clk), .rst(rst),
      .req0(a_req0[gi]), .we0(a_we0[gi]), .adr0(a_adr0[gi]), .wdat0(a_wdat0[gi]),
      .gnt0(a_gnt0[gi]), .done0(a_done0[gi]),
      .req1(1'b0), .we1(1'b0), .adr1(19'd0), .wdat1(16'd0),
      .gnt1(a_gnt1[gi]), .done1(a_done1[gi]),
      .rdata(a_rdata[gi]), .sram_adr(a_sadr[gi]), .sram_dat_o(a_sdo[gi]),
      .sram_dat_oe(a_sdoe[gi]), .sram_dat_i(a_sdi), .sram_oe_n(a_oe_n[gi]),
      .sram_we_n(a_we_n[gi]), .sram_cs_n(a_cs_n[gi])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // External SRAM behaviour and the reference memory image.
  logic [15:0] sram_mem [logic [18:0]];
  logic [15:0] ref_mem  [logic [18:0]];

  function automatic logic [15:0] fill(input logic [18:0] a);
    return a[15:0] ^ 16'h5a5a ^ {13'd0, a[18:16]};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  // Reference model: an access granted on edge g_edge owns the bus for W+2 cycles
  // counted from that edge; phase 0 is setup, 1..W the strobe, W+1 the hold with done.
  logic        busy = 1'b0;
  int          g_edge;
  logic        g_port, g_we, last_owner = 1'b1;
  logic [18:0] g_adr;
  logic [15:0] g_wdat, g_rexp, exp_rdata = 16'd0;

  // Observation counters for the directed scenarios.
  int cs_cnt, oe_cnt, we_cnt, d0_cnt, d1_cnt, g0_cnt, g1_cnt, d_edge, ge;

  task automatic clr_cnt();
    cs_cnt = 0; oe_cnt = 0; we_cnt = 0; d0_cnt = 0; d1_cnt = 0; g0_cnt = 0; g1_cnt = 0;
    d_edge = -1; ge = -1;
  endtask

  task automatic check_outputs();
    logic e_cs, e_oe, e_we, e_doe, e_d0, e_d1;
    int ph;
    e_cs = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_doe = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
    ph = 0;
    if (busy) begin
      ph = edge_cnt - g_edge;
      if (ph > int'(W) + 1) busy = 1'b0;
    end
    if (busy) begin
      e_cs  = 1'b0;
      e_doe = g_we;
      if (ph >= 1 && ph <= int'(W)) begin
        if (g_we) e_we = 1'b0;
        else      e_oe = 1'b0;
      end
      if (ph == int'(W) + 1) begin
        if (g_port) e_d1 = 1'b1;
        else        e_d0 = 1'b1;
        if (!g_we) exp_rdata = g_rexp;
      end
      check("adr", 32'(sram_adr), 32'(g_adr));
      if (g_we) check("dat_o", 32'(sram_dat_o), 32'(g_wdat));
    end
    check("cs_n", 32'(sram_cs_n), 32'(e_cs));
    check("oe_n", 32'(sram_oe_n), 32'(e_oe));
    check("we_n", 32'(sram_we_n), 32'(e_we));
    check("dat_oe", 32'(sram_dat_oe), 32'(e_doe));
    check("done0", 32'(done0), 32'(e_d0));
    check("done1", 32'(done1), 32'(e_d1));
    check("rdata", 32'(rdata), 32'(exp_rdata));
  endtask

  // One cycle: sample at the falling edge, then let the SRAM model react.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    if (!sram_cs_n) cs_cnt++;
    if (!sram_oe_n) oe_cnt++;
    if (!sram_we_n) we_cnt++;
    if (done0) begin d0_cnt++; d_edge = edge_cnt; end
    if (done1) begin d1_cnt++; d_edge = edge_cnt; end
    if (!sram_cs_n && !sram_we_n) sram_mem[sram_adr] = sram_dat_o;
    sram_dat_i = sram_mem.exists(sram_adr) ? sram_mem[sram_adr] : fill(sram_adr);
  endtask

  // After inputs are set for this cycle, predict and check the grants.
  task automatic arb_check();
    logic e0, e1;
    #1;
    e0 = 1'b0; e1 = 1'b0;
    if (!busy) begin
      if (req0 && req1) begin e0 = last_owner; e1 = ~last_owner; end
      else begin e0 = req0; e1 = req1; end
    end
    check("gnt0", 32'(gnt0), 32'(e0));
    check("gnt1", 32'(gnt1), 32'(e1));
    if (gnt0) begin g0_cnt++; ge = edge_cnt + 1; end
    if (gnt1) begin g1_cnt++; ge = edge_cnt + 1; end
    if (e0 || e1) begin
      busy       = 1'b1;
      g_edge     = edge_cnt + 1;
      g_port     = e1;
      last_owner = e1;
      g_we       = e1 ? we1 : we0;
      g_adr      = e1 ? adr1 : adr0;
      g_wdat     = e1 ? wdat1 : wdat0;
      if (g_we) ref_mem[g_adr] = g_wdat;
      else      g_rexp = ref_rd(g_adr);
    end
  endtask

  task automatic new_req(input int p);
    logic        w;
    logic [18:0] a;
    logic [15:0] d;
    w = 1'($urandom_range(0, 1));
    a = 19'h00010 + 19'($urandom_range(0, 15));
    d = 16'($urandom);
    if (p == 0) begin req0 = 1'b1; we0 = w; adr0 = a; wdat0 = d; end
    else        begin req1 = 1'b1; we1 = w; adr1 = a; wdat1 = d; end
  endtask

  // Drop a port's request after its grant, or renew it with fresh fields.
  task automatic after_grant(input logic s0, input logic s1, input logic renew0,
                             input logic renew1);
    if (s0) begin if (renew0) new_req(0); else req0 = 1'b0; end
    if (s1) begin if (renew1) new_req(1); else req1 = 1'b0; end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      arb_check();
    end
  endtask

  // Strobe width and grant-to-done latency on one of the extra builds.
  task automatic alt_run(input int i, input logic wr, input int wc);
    int n, low, lat;
    @(negedge clk);
    a_req0[i] = 1'b1; a_we0[i] = wr; a_adr0[i] = 19'h00100; a_wdat0[i] = 16'h1357;
    #1;
    n = -1;
    for (int t = 0; t < 40 && n < 0; t++) begin
      if (a_gnt0[i]) n = edge_cnt + 1;
      else begin @(negedge clk); #1; end
    end
    @(negedge clk);
    a_req0[i] = 1'b0;
    low = 0; lat = -1;
    for (int t = 0; t < 40 && n >= 0 && lat < 0; t++) begin
      if (t > 0) @(negedge clk);
      if (wr ? !a_we_n[i] : !a_oe_n[i]) low++;
      if (wr ? !a_oe_n[i] : !a_we_n[i]) low += 100;
      if (a_done0[i]) lat = edge_cnt - n + 1;
    end
    check("alt_width", 32'(low), 32'(wc));
    check("alt_latency", 32'(lat), 32'(wc + 2));
    if (!wr) check("alt_rdata", 32'(a_rdata[i]), 32'h0000c3c3);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s0, s1, ok;
    int   ng, last_ge, last_port, waited;

    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; adr0 = '0; wdat0 = '0;
    req1 = 1'b0; we1 = 1'b0; adr1 = '0; wdat1 = '0;
    sram_dat_i = '0;
    a_sdi = 16'hc3c3;
    for (int i = 0; i < 2; i++) begin
      a_req0[i] = 1'b0; a_we0[i] = 1'b0; a_adr0[i] = '0; a_wdat0[i] = '0;
    end
    clr_cnt();

    // Reset values.
    repeat (3) tick();
    rst = 1'b0;
    idle_cycles(2);

    // Single write from port 0.
    clr_cnt();
    tick();
    req0 = 1'b1; we0 = 1'b1; adr0 = 19'h12345; wdat0 = 16'hbeef;
    arb_check();
    s0 = gnt0;
    for (int i = 0; i < 8; i++) begin
      tick();
      after_grant(s0, 1'b0, 1'b0, 1'b0);
      s0 = 1'b0;
      arb_check();
    end
    check("wr_gnt_cycles", 32'(g0_cnt), 32'd1);
    check("wr_cs_width", 32'(cs_cnt), 32'(W + 2));
    check("wr_we_width", 32'(we_cnt), 32'(W));
    check("wr_oe_width", 32'(oe_cnt), 32'd0);
    check("wr_done0", 32'(d0_cnt), 32'd1);
    check("wr_done1", 32'(d1_cnt), 32'd0);
    // done rises on the (W+1)th edge after the grant edge.
    check("wr_latency", 32'(d_edge - ge), 32'(W + 1));

    // Reset in the middle of a write strobe.
    tick();
    req0 = 1'b1; we0 = 1'b1; adr0 = 19'h7ffff; wdat0 = 16'h0f0f;
    arb_check();
    tick();
    req0 = 1'b0;
    arb_check();
    tick();
    rst = 1'b1;
    #1;
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_cs_n", 32'(sram_cs_n), 32'd1);
    check("rst_dat_oe", 32'(sram_dat_oe), 32'd0);
    check("rst_adr", 32'(sram_adr), 32'd0);
    check("rst_dat_o", 32'(sram_dat_o), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    busy = 1'b0; last_owner = 1'b1; exp_rdata = 16'd0;
    repeat (2) tick();
    rst = 1'b0;
    idle_cycles(2);

    // Single read from port 1.
    sram_mem[19'h00010] = 16'ha5a5;
    ref_mem[19'h00010]  = 16'ha5a5;
    clr_cnt();
    tick();
    req1 = 1'b1; we1 = 1'b0; adr1 = 19'h00010;
    arb_check();
    s1 = gnt1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done1) check("rd_rdata", 32'(rdata), 32'h0000a5a5);
      after_grant(1'b0, s1, 1'b0, 1'b0);
      s1 = 1'b0;
      arb_check();
    end
    check("rd_oe_width", 32'(oe_cnt), 32'(W));
    check("rd_we_width", 32'(we_cnt), 32'd0);
    check("rd_done1", 32'(d1_cnt), 32'd1);
    check("rd_done0", 32'(d0_cnt), 32'd0);

    // Contention: both ports request continuously.
    tick();
    new_req(0);
    new_req(1);
    arb_check();
    s0 = gnt0; s1 = gnt1;
    ng = 0; last_ge = 0; last_port = -1;
    for (int i = 0; i < 60 && ng < 8; i++) begin
      if (s0 || s1) begin
        if (ng > 0) begin
          check("cont_gap", 32'(edge_cnt - last_ge), 32'(W + 3));
          check("cont_alt", 32'(s1 != last_port[0]), 32'd1);
        end
        last_ge = edge_cnt; last_port = int'(s1); ng++;
      end
      tick();
      after_grant(s0, s1, 1'b1, 1'b1);
      arb_check();
      s0 = gnt0; s1 = gnt1;
    end
    check("cont_grants", 32'(ng), 32'd8);
    tick();
    after_grant(s0, s1, 1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    arb_check();
    idle_cycles(8);

    // Starvation: port 0 keeps requesting, port 1 asks once.
    tick();
    new_req(0);
    arb_check();
    s0 = gnt0; s1 = 1'b0;
    ng = 0; ok = 1'b0; waited = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      after_grant(s0, s1, 1'b1, 1'b0);
      if (i == 6) begin new_req(1); waited = 1; end
      arb_check();
      s0 = gnt0; s1 = gnt1;
      if (waited == 1 && gnt0) ng++;
      if (gnt1) ok = 1'b1;
    end
    check("starve_granted", 32'(ok), 32'd1);
    check("starve_bound", 32'(ng <= 1), 32'd1);
    tick();
    after_grant(s0, s1, 1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    arb_check();
    idle_cycles(8);

    // Randomized traffic.
    s0 = 1'b0; s1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      after_grant(s0, s1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      if (!req0 && $urandom_range(0, 2) == 0) new_req(0);
      if (!req1 && $urandom_range(0, 2) == 0) new_req(1);
      arb_check();
      s0 = gnt0; s1 = gnt1;
    end
    tick();
    after_grant(s0, s1, 1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    arb_check();
    idle_cycles(8);

    // WAIT_CYCLES extremes.
    alt_run(0, 1'b0, 1);
    alt_run(0, 1'b1, 1);
    alt_run(1, 1'b0, 15);
    alt_run(1, 1'b1, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
